// File: rtl/os_row_drain_pkg.sv
// Shared constants and state encoding for the output-stationary row drain.
package os_row_drain_pkg;

  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned COL     = 8;
  localparam int unsigned CNT_BW  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_e;

endpackage

// File: rtl/os_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set request plus an any-set flag.
module os_prio_enc #(
  parameter int unsigned n = 8
) (
  input  logic [n-1:0]         req,
  output logic [$clog2(n)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(n);

  // Scan upward and latch the first set bit seen.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (req[i] && !any) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/os_row_drain.sv
// Captures per-column psums from one output-stationary MAC row, optionally
// applies ReLU, and serializes them lowest column first onto a valid/ready stream.
module os_row_drain
  import os_row_drain_pkg::*;
#(
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned col     = COL,
  parameter int unsigned cnt_bw  = CNT_BW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col-1:0]           os_ready,
  input  logic [psum_bw*col-1:0]   os_output,
  input  logic                     relu_en,
  output logic [psum_bw-1:0]       out_data,
  output logic [$clog2(col)-1:0]   out_col,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     tile_done,
  output logic [cnt_bw-1:0]        tile_cnt,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam int unsigned CW  = $clog2(col);
  localparam int unsigned WCW = $clog2(col + 1);

  logic [psum_bw-1:0] cap_q [col];
  logic [psum_bw-1:0] cap_d [col];
  logic [col-1:0]     pend_q, pend_d;
  logic [psum_bw-1:0] out_data_q, out_data_d;
  logic [CW-1:0]      out_col_q, out_col_d;
  logic               out_valid_q, out_valid_d;
  drain_state_e       state_q, state_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic               tile_done_q, tile_done_d;
  logic [cnt_bw-1:0]  tile_cnt_q, tile_cnt_d;
  logic               overrun_q, overrun_d;

  logic [CW-1:0]      sel_idx;
  logic               sel_any;
  logic               accept;
  logic               loadable;
  logic               load;
  logic               ovr_hit;

  os_prio_enc #(.n(col)) u_prio (
    .req (pend_q),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Next-state: output load, capture with slot-free check, FSM, tile accounting, overrun.
  always_comb begin
    accept      = out_valid_q && out_ready;
    loadable    = !out_valid_q || out_ready;
    load        = loadable && sel_any;
    ovr_hit     = 1'b0;

    cap_d       = cap_q;
    pend_d      = pend_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    out_valid_d = out_valid_q;
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    tile_done_d = 1'b0;
    tile_cnt_d  = tile_cnt_q;

    if (load) begin
      out_data_d      = cap_q[sel_idx];
      out_col_d       = sel_idx;
      out_valid_d     = 1'b1;
      pend_d[sel_idx] = 1'b0;
    end else if (loadable) begin
      out_valid_d = 1'b0;
    end

    // Capture runs after the load clear so a slot freed this edge can be refilled.
    for (int unsigned i = 0; i < col; i++) begin
      if (os_ready[i]) begin
        if (!pend_q[i] || (load && sel_idx == CW'(i))) begin
          cap_d[i]  = (relu_en && os_output[psum_bw*i + psum_bw - 1]) ? '0
                                                                     : os_output[psum_bw*i +: psum_bw];
          pend_d[i] = 1'b1;
        end else begin
          ovr_hit = 1'b1;
        end
      end
    end

    unique case (state_q)
      IDLE: if (sel_any) state_d = SEND;
      SEND: if (accept && !sel_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (wcnt_q == WCW'(col - 1)) begin
        wcnt_d      = '0;
        tile_done_d = 1'b1;
        tile_cnt_d  = tile_cnt_q + cnt_bw'(1);
      end else begin
        wcnt_d = wcnt_q + WCW'(1);
      end
    end

    if (ovr_hit)          overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
    else                  overrun_d = overrun_q;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q       <= '{default: '0};
      pend_q      <= '0;
      out_data_q  <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
      wcnt_q      <= '0;
      tile_done_q <= 1'b0;
      tile_cnt_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      pend_q      <= pend_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      tile_done_q <= tile_done_d;
      tile_cnt_q  <= tile_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_col   = out_col_q;
  assign out_valid = out_valid_q;
  assign tile_done = tile_done_q;
  assign tile_cnt  = tile_cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_os_row_drain.sv
// Scoreboard bench for os_row_drain: expected words queued at stimulus, checked on accept.
module tb_os_row_drain;

  localparam int unsigned PB = 16;
  localparam int unsigned NC = 8;
  localparam int unsigned CB = 16;

  typedef struct {
    logic [PB-1:0] d;
    logic [2:0]    c;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     os_ready = '0;
  logic [PB*NC-1:0]  os_output = '0;
  logic              relu_en = 1'b0;
  logic [PB-1:0]     out_data;
  logic [2:0]        out_col;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              tile_done;
  logic [CB-1:0]     tile_cnt;
  logic              overrun;
  logic              overrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t          sb[$];
  exp_t          e;
  int            wc = 0;
  logic          exp_td = 1'b0;
  logic [CB-1:0] exp_cnt = '0;
  logic          hold = 1'b0;
  logic [PB-1:0] hd;
  logic [2:0]    hc;

  os_row_drain #(.psum_bw(PB), .col(NC), .cnt_bw(CB)) dut (
    .clk         (clk),
    .reset       (reset),
    .os_ready    (os_ready),
    .os_output   (os_output),
    .relu_en     (relu_en),
    .out_data    (out_data),
    .out_col     (out_col),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .tile_done   (tile_done),
    .tile_cnt    (tile_cnt),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge: scoreboard pops, hold stability, tile model.
  always @(negedge clk) begin
    if (reset) begin
      wc = 0; exp_td = 1'b0; exp_cnt = '0; hold = 1'b0;
    end else begin
      checks++;
      if (tile_done !== exp_td) begin
        errors++; $display("FAIL tile_done: got %b expected %b", tile_done, exp_td);
      end
      checks++;
      if (tile_cnt !== exp_cnt) begin
        errors++; $display("FAIL tile_cnt: got %0d expected %0d", tile_cnt, exp_cnt);
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hd || out_col !== hc) begin
          errors++;
          $display("FAIL hold_stable: got v=%b d=%h c=%0d expected v=1 d=%h c=%0d",
                   out_valid, out_data, out_col, hd, hc);
        end
      end
      hold = (out_valid === 1'b1) && (out_ready === 1'b0);
      hd = out_data; hc = out_col;
      exp_td = 1'b0;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL unexpected_word: got d=%h c=%0d expected none", out_data, out_col);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_col !== e.c) begin
            errors++;
            $display("FAIL word: got d=%h c=%0d expected d=%h c=%0d", out_data, out_col, e.d, e.c);
          end
        end
        wc++;
        if (wc == NC) begin
          wc = 0; exp_td = 1'b1; exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || out_valid !== 1'b0) && n < budget) begin
      tick(); n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_timeout: got %0d words left expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_col !== '0) begin
      errors++; $display("FAIL reset_out: got v=%b d=%h c=%0d expected 0/0/0", out_valid, out_data, out_col);
    end
    checks++;
    if (tile_done !== 1'b0 || tile_cnt !== '0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_stat: got td=%b cnt=%0d ov=%b expected 0/0/0", tile_done, tile_cnt, overrun);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_tile();
    out_ready = 1'b1;
    for (int i = 0; i < NC; i++) begin
      os_output[PB*i +: PB] = PB'(i + 1);
      sb.push_back('{d: PB'(i + 1), c: 3'(i)});
    end
    os_ready = '1;
    tick();
    os_ready = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_col !== 3'd0 || out_data !== 16'd1) begin
      errors++; $display("FAIL first_latency: got v=%b c=%0d d=%h expected 1/0/0001", out_valid, out_col, out_data);
    end
    repeat (7) tick();
    checks++;
    if (out_valid !== 1'b1 || out_col !== 3'd7 || out_data !== 16'd8) begin
      errors++; $display("FAIL last_word: got v=%b c=%0d d=%h expected 1/7/0008", out_valid, out_col, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0 || tile_cnt !== 16'd1) begin
      errors++; $display("FAIL tile_end: got v=%b left=%0d cnt=%0d expected 0/0/1", out_valid, sb.size(), tile_cnt);
    end
  endtask

  task automatic test_relu();
    out_ready = 1'b1;
    relu_en = 1'b1;
    os_output[PB*3 +: PB] = 16'hFFF0;
    os_output[PB*5 +: PB] = 16'h0007;
    sb.push_back('{d: 16'h0000, c: 3'd3});
    sb.push_back('{d: 16'h0007, c: 3'd5});
    os_ready = 8'b0010_1000;
    tick();
    os_ready = '0;
    relu_en = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    os_output[PB*2 +: PB] = 16'h1234;
    sb.push_back('{d: 16'h1234, c: 3'd2});
    os_ready = 8'b0000_0100;
    tick();
    os_ready = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_valid: got %b expected 1", out_valid);
    end
    repeat (10) tick();
    checks++;
    if (out_valid !== 1'b1 || out_col !== 3'd2 || out_data !== 16'h1234 || sb.size() != 1) begin
      errors++; $display("FAIL bp_held: got v=%b c=%0d d=%h left=%0d expected 1/2/1234/1",
                         out_valid, out_col, out_data, sb.size());
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL bp_one_accept: got v=%b left=%0d expected 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    os_output[PB*5 +: PB] = 16'h0C5C;
    sb.push_back('{d: 16'h0C5C, c: 3'd5});
    os_ready = 8'b0010_0000;
    tick();
    os_ready = '0;
    tick();
    os_output[PB*4 +: PB] = 16'h00AA;
    sb.push_back('{d: 16'h00AA, c: 3'd4});
    os_ready = 8'b0001_0000;
    tick();
    os_ready = '0;
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_early: got %b expected 0", overrun);
    end
    os_output[PB*4 +: PB] = 16'h00BB;
    os_ready = 8'b0001_0000;
    tick();
    os_ready = '0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_set: got %b expected 1", overrun);
    end
    out_ready = 1'b1;
    wait_drain(20);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clr: got %b expected 0", overrun);
    end
  endtask

  task automatic test_accept_recapture();
    out_ready = 1'b0;
    os_output[PB*1 +: PB] = 16'h0011;
    sb.push_back('{d: 16'h0011, c: 3'd1});
    os_ready = 8'b0000_0010;
    tick();
    os_ready = '0;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b1 || out_col !== 3'd1) begin
      errors++; $display("FAIL rc_held: got v=%b c=%0d expected 1/1", out_valid, out_col);
    end
    out_ready = 1'b1;
    os_output[PB*1 +: PB] = 16'h0055;
    sb.push_back('{d: 16'h0055, c: 3'd1});
    os_ready = 8'b0000_0010;
    tick();
    os_ready = '0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL rc_no_ovr: got %b expected 0", overrun);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_col !== 3'd1 || out_data !== 16'h0055) begin
      errors++; $display("FAIL rc_next: got v=%b c=%0d d=%h expected 1/1/0055", out_valid, out_col, out_data);
    end
    wait_drain(20);
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) os_output[PB*i +: PB] = PB'(16'h0100 + i);
    os_ready = 8'b0000_1111;
    tick();
    os_ready = '0;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b1 || tile_cnt !== 16'd1) begin
      errors++; $display("FAIL pre_reset: got v=%b cnt=%0d expected 1/1", out_valid, tile_cnt);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || tile_cnt !== '0 || overrun !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got v=%b cnt=%0d ov=%b expected 0/0/0", out_valid, tile_cnt, overrun);
    end
    sb.delete();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (out_valid !== 1'b0 || tile_cnt !== '0) begin
      errors++; $display("FAIL post_reset: got v=%b cnt=%0d expected 0/0", out_valid, tile_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_tile();
    test_relu();
    test_backpressure();
    test_overrun();
    test_accept_recapture();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/os_row_drain.md
Name: os_row_drain

Overview:
- Consumer side of one output-stationary MAC row's result interface.
- Captures each column's finished psum when that column's os_ready is high.
- Optionally applies ReLU and serializes the captured psums, lowest column first, onto a single valid/ready stream toward output SRAM or the PSUM FIFO.
- Counts completed tiles and flags overruns (a column finishing again before its previous result was drained).

Parameters:
psum_bw, 16, width of one column psum / output word
col, 8, number of columns in the row
cnt_bw, 16, width of the tile counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
os_ready  input  col  per-column result-ready strobe from the row; bit i qualifies os_output slice i
os_output  input  psum_bw*col  column psums; column i at [psum_bw*(i+1)-1 : psum_bw*i]
relu_en  input  1  clamp negative (two's-complement) psums to 0 on capture
out_data  output  psum_bw  serialized psum
out_col  output  $clog2(col)  column index of out_data
out_valid  output  1  out_data/out_col valid
out_ready  input  1  downstream accept
tile_done  output  1  one-cycle pulse when the col-th word of a tile is accepted
tile_cnt  output  cnt_bw  number of completed tiles; wraps modulo 2^cnt_bw
overrun  output  1  sticky error flag
overrun_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, active-high): all state is cleared.
  - capture regs 0, pending 0, out_data 0, out_col 0, out_valid 0.
  - word counter 0, tile_done 0, tile_cnt 0, overrun 0, FSM in IDLE.
- Capture: at each edge, for every i with os_ready[i]=1 and slot i free, cap[i] <= (relu_en && os_output_i[psum_bw-1]) ? 0 : os_output_i, and pending[i] <= 1.
- Slot i is free if pending[i]=0, or if pending[i] is being loaded into the output register on the same edge.
- Overrun: os_ready[i]=1 with slot i not free → the new value is dropped, cap[i] is unchanged, and overrun <= 1. Overrun holds until overrun_clr or reset. A new overrun on the same edge as overrun_clr wins (flag stays 1).
- Output register: loadable when out_valid=0, or when out_valid && out_ready (the current word is accepted).
  - When loadable and any pending bit is set, select the lowest set index k.
  - out_data <= cap[k], out_col <= k, out_valid <= 1, pending[k] <= 0.
  - When loadable and nothing is pending, out_valid <= 0.
- Back-to-back throughput is 1 word/cycle.
- The pending bit clears on load into the output register, not on acceptance.
- Latency: os_ready[i] sampled at edge N with no other pending work → out_valid=1, out_col=i after edge N+1.
- Handshake: while out_valid && !out_ready, out_data and out_col are held stable. out_valid never drops without acceptance.
- FSM:
  - IDLE (out_valid=0): any pending → SEND.
  - SEND: on accept with no pending → IDLE; otherwise remain.
- Tile accounting: word counter increments on each accept.
  - On the accept that brings the counter to col: counter <= 0, tile_done pulses for 1 cycle, tile_cnt += 1.
  - tile_cnt wraps to 0 after its maximum value.
- Simultaneous events:
  - Capture of column j and load of column k<j on the same edge: both happen.
  - A column whose slot is freed by a load on the same edge may recapture on that edge.
- Reset mid-stream: out_valid drops immediately and all captured data is discarded.

Decomposition:
- Shared package holds the default PSUM_BW/COL constants and the FSM state encoding (IDLE=0, SEND=1).
- One natural sub-module, os_prio_enc: combinational lowest-set-bit priority encoder over col bits, producing the index and an any-set flag. It is reused by the drain and by future multi-row arbiters.

Test Plan:
1. After reset, os_ready=8'hFF, column i = i+1, out_ready=1 → out_col 0..7 on 8 consecutive cycles, out_data 1..8, tile_done pulses once with the last word, tile_cnt=1.
2. relu_en=1, col 3 = 16'hFFF0, col 5 = 16'h0007 → out_data 0 (col 3), then 7 (col 5).
3. out_ready=0 for 10 cycles after out_valid rises on col 2 = 16'h1234 → out_data/out_col stay stable, then exactly one accept when out_ready=1.
4. Capture col 4 = 16'h00AA; with out_ready=0 and col 5 blocking the output register, pulse os_ready[4] again with 16'h00BB → overrun=1, 16'h00AA is later emitted, 16'h00BB never appears; overrun_clr → overrun=0.
5. Stream held by out_ready=0 with col 1 loaded; pulse os_ready[1] = 16'h0055 on the edge the held word is accepted → no overrun, 16'h0055 is emitted next.
6. Assert reset mid-stream with 3 words pending → out_valid=0 immediately, no further words are emitted, tile_cnt=0.
